// File: rtl/conveng_pkg.sv
// Shared types and constants for the conveng front end.
// RF_ROWS matches the register-file depth of conveng.
package conveng_pkg;

   localparam int PIX_W     = 8;
   localparam int ROW_PIX   = 22;
   localparam int ROW_W     = 180;
   localparam int COL_STEPS = 18;
   localparam int RF_ROWS   = 16;

   localparam logic [3:0] FLAG_NIBBLE = 4'hF;

   typedef logic [ROW_W-1:0] row_word_t;

   typedef enum logic [1:0] {
      FILL,
      SCAN,
      WAIT_ROW
   } feed_state_t;

endpackage

// File: rtl/conv_row_feeder_row_packer.sv
// Packs accepted pixels into a row word and holds at most one finished row
// until the sequencer is ready to take it.
module row_packer
  import conveng_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix,
  input  logic             pix_valid,
  input  logic             frame_start,
  input  logic             emit_ok,
  output logic             pix_ready,
  output logic             take,
  output logic             new_frame,
  output row_word_t        row_word
);

  localparam int PACK_W = ROW_PIX * PIX_W;

  logic [PACK_W-1:0] pack;
  logic [4:0]        pix_cnt;
  logic              pending;
  logic              alive;
  logic              accept;
  logic              last_pix;
  logic [7:0]        slot_lsb;

  // alive keeps ready low for the whole reset and the first cycle after it
  assign pix_ready = alive && !pending;
  assign accept    = pix_valid && pix_ready;
  assign new_frame = accept && frame_start;
  assign last_pix  = accept && !frame_start && (pix_cnt == 5'(ROW_PIX - 1));
  assign take      = emit_ok && (pending || last_pix);
  assign slot_lsb  = 8'(PACK_W - PIX_W) - {pix_cnt, 3'b000};

  // A row finishing on this very pixel bypasses the pack register
  assign row_word = pending ? {pack, FLAG_NIBBLE}
                            : {pack[PACK_W-1:PIX_W], pix, FLAG_NIBBLE};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pack    <= '0;
      pix_cnt <= '0;
      pending <= 1'b0;
      alive   <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (new_frame) begin
        pack[PACK_W-1 -: PIX_W] <= pix;
        pix_cnt                 <= 5'd1;
        pending                 <= 1'b0;
      end else if (accept) begin
        pack[slot_lsb +: PIX_W] <= pix;
        if (last_pix) begin
          pix_cnt <= '0;
          pending <= !take;
        end else begin
          pix_cnt <= pix_cnt + 5'd1;
        end
      end else if (take) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/conv_row_feeder.sv
// Feeds conveng: fills its register file with RF_ROWS rows, then alternates
// one column sweep with one new row.
module conv_row_feeder
  import conveng_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic             frame_start_i,
  output logic [179:0]     data,
  output logic             rowShift,
  output logic             colShift,
  output logic             scan_done_o
);

  localparam int RC_W = $clog2(RF_ROWS);
  localparam int CC_W = $clog2(COL_STEPS);

  feed_state_t     state, state_nx;
  logic [RC_W-1:0] row_cnt, row_cnt_nx;
  logic [CC_W-1:0] col_cnt, col_cnt_nx;
  logic            emit_ok;
  logic            take;
  logic            new_frame;
  row_word_t       row_word;

  row_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .pix         (pix_i),
    .pix_valid   (pix_valid_i),
    .frame_start (frame_start_i),
    .emit_ok     (emit_ok),
    .pix_ready   (pix_ready_o),
    .take        (take),
    .new_frame   (new_frame),
    .row_word    (row_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data     <= '0;
      rowShift <= 1'b0;
    end else begin
      rowShift <= take;
      if (take) begin
        data <= row_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FILL;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      state   <= state_nx;
      row_cnt <= row_cnt_nx;
      col_cnt <= col_cnt_nx;
    end
  end

  // Transitions key off the rowShift pulse itself, so a sweep always begins
  // the cycle after the row that triggered it. The last sweep cycle may hand
  // over a held row so its rowShift lands in the first WAIT_ROW cycle.
  always_comb begin
    state_nx    = state;
    row_cnt_nx  = row_cnt;
    col_cnt_nx  = col_cnt;
    emit_ok     = 1'b0;
    colShift    = 1'b0;
    scan_done_o = 1'b0;
    case (state)
      FILL: begin
        emit_ok = !rowShift;
        if (rowShift) begin
          if (row_cnt == RC_W'(RF_ROWS - 1)) begin
            row_cnt_nx = '0;
            state_nx   = SCAN;
          end else begin
            row_cnt_nx = row_cnt + 1'b1;
          end
        end
      end
      SCAN: begin
        colShift = 1'b1;
        if (col_cnt == CC_W'(COL_STEPS - 1)) begin
          scan_done_o = 1'b1;
          emit_ok     = 1'b1;
          col_cnt_nx  = '0;
          state_nx    = WAIT_ROW;
        end else begin
          col_cnt_nx = col_cnt + 1'b1;
        end
      end
      WAIT_ROW: begin
        emit_ok = !rowShift;
        if (rowShift) begin
          state_nx = SCAN;
        end
      end
      default: state_nx = FILL;
    endcase
    if (new_frame) begin
      state_nx   = FILL;
      row_cnt_nx = '0;
      col_cnt_nx = '0;
    end
  end

endmodule

// File: tb/tb_conv_row_feeder.sv
// Self-checking bench for conv_row_feeder: a row/sweep model judges every
// cycle while directed sequences pin a few hand-computed values.
module tb_conv_row_feeder;

  localparam int NPIX  = 22;
  localparam int NROWS = 16;
  localparam int NCOL  = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   pix_i;
  logic         pix_valid_i;
  logic         frame_start_i;
  logic         pix_ready_o;
  logic [179:0] data;
  logic         rowShift;
  logic         colShift;
  logic         scan_done_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  conv_row_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .pix_i         (pix_i),
    .pix_valid_i   (pix_valid_i),
    .pix_ready_o   (pix_ready_o),
    .frame_start_i (frame_start_i),
    .data          (data),
    .rowShift      (rowShift),
    .colShift      (colShift),
    .scan_done_o   (scan_done_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [179:0] act,
                              input logic [179:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: rows are rebuilt from the accepted pixel stream, and the
  // sweep rules are checked as run lengths and row counts between sweeps.
  logic [7:0]   cur [NPIX];
  int           cur_n;
  logic [179:0] exp_q [$];
  int           rows_since, rows_needed, run, rel_cnt, ncyc, comp_cyc;
  logic         comp_col, prev_rs;

  always @(negedge clk) begin
    if (!reset) begin
      check_output("reset_data", data, 180'd0);
      check_output("reset_flags", 180'({rowShift, colShift, scan_done_o, pix_ready_o}), 180'd0);
      cur_n = 0; exp_q.delete(); rows_since = 0; rows_needed = NROWS;
      run = 0; rel_cnt = 0; prev_rs = 1'b0;
    end else begin
      if (colShift) begin
        if (run == 0) begin
          check_output("sweep_rows", 180'(rows_since), 180'(rows_needed));
          check_output("sweep_after_row", 180'(prev_rs), 180'd1);
        end
        check_output("scan_done", 180'(scan_done_o), 180'(run == NCOL - 1));
        run++;
      end else begin
        check_output("scan_done_idle", 180'(scan_done_o), 180'd0);
        if (run != 0) begin
          check_output("sweep_len", 180'(run), 180'(NCOL));
          run = 0; rows_since = 0; rows_needed = 1;
        end
      end
      if (rowShift) begin
        check_output("row_expected", 180'(exp_q.size() != 0), 180'd1);
        if (exp_q.size() != 0) begin
          check_output("row_data", data, exp_q.pop_front());
          if (!comp_col) check_output("row_latency", 180'(ncyc - comp_cyc), 180'd1);
        end
        rows_since++;
      end
      check_output("no_overlap", 180'(rowShift & colShift), 180'd0);
      check_output("ready", 180'(pix_ready_o), 180'(rel_cnt >= 1 && exp_q.size() == 0));
      if (pix_valid_i && pix_ready_o) begin
        if (frame_start_i) begin
          cur_n = 0; rows_since = 0; rows_needed = NROWS;
        end
        cur[cur_n] = pix_i;
        cur_n++;
        if (cur_n == NPIX) begin
          logic [179:0] w;
          w = '0;
          for (int k = 0; k < NPIX; k++) w[179 - 8*k -: 8] = cur[k];
          w[3:0] = 4'hF;
          exp_q.push_back(w);
          cur_n = 0; comp_cyc = ncyc; comp_col = colShift;
        end
      end
      prev_rs = rowShift;
      rel_cnt++;
      ncyc++;
    end
  end

  task automatic apply_stimulus(input logic [7:0] p, input logic fs);
    int waitc = 0;
    pix_i = p; pix_valid_i = 1'b1; frame_start_i = fs;
    @(negedge clk);
    while (!pix_ready_o && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) check_output("accept_timeout", 180'(pix_ready_o), 180'd1);
    @(posedge clk); #1;
    pix_valid_i = 1'b0; frame_start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [179:0] lit;
    reset = 1'b0; pix_i = '0; pix_valid_i = 1'b0; frame_start_i = 1'b0;
    idle(3);
    reset = 1'b1;
    check_output("ready_first_cycle", 180'(pix_ready_o), 180'd0);

    // Fill: row r carries byte r everywhere, valid held high
    for (int r = 0; r < NROWS; r++) begin
      for (int k = 0; k < NPIX; k++) begin
        apply_stimulus(8'(r), 1'b0);
        if (r == 0 && k == NPIX - 2) check_output("row0_early", 180'(rowShift), 180'd0);
      end
      if (r == 0) begin
        lit = '0; lit[3:0] = 4'hF;
        check_output("row0_pulse", 180'(rowShift), 180'd1);
        check_output("row0_data", data, lit);
      end
    end
    lit = {{22{8'h0F}}, 4'hF};
    check_output("row15_data", data, lit);
    check_output("row15_pulse", 180'(rowShift), 180'd1);
    check_output("no_col_on_row15", 180'(colShift), 180'd0);
    idle(1);
    check_output("scan_start", 180'(colShift), 180'd1);
    idle(17);
    check_output("scan_last_col", 180'(colShift), 180'd1);
    check_output("scan_done_18th", 180'(scan_done_o), 180'd1);
    idle(1);
    check_output("scan_end", 180'(colShift), 180'd0);

    // Single row after the sweep
    for (int k = 0; k < NPIX; k++) apply_stimulus(8'hEA, 1'b0);
    lit = {{22{8'hEA}}, 4'hF};
    check_output("ea_data", data, lit);
    check_output("ea_pulse", 180'(rowShift), 180'd1);
    idle(1);
    check_output("ea_scan", 180'(colShift), 180'd1);

    // Continuous stream straight through the following sweeps
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NPIX; k++) apply_stimulus(8'(8'h30 + r + k), 1'b0);
    idle(25);

    // New frame, then a second frame start at row 7 pixel 10
    for (int r = 0; r < 7; r++)
      for (int k = 0; k < NPIX; k++) apply_stimulus(8'(8'h80 + r), (r == 0 && k == 0));
    for (int k = 0; k < 10; k++) apply_stimulus(8'h87, 1'b0);
    for (int r = 0; r < NROWS; r++) begin
      for (int k = 0; k < NPIX; k++) apply_stimulus(8'(8'hA0 + r + k), (r == 0 && k == 0));
      if (r == NROWS - 2) check_output("no_early_sweep", 180'(colShift), 180'd0);
    end
    lit = '0;
    for (int k = 0; k < NPIX; k++) lit[179 - 8*k -: 8] = 8'(8'hAF + k);
    lit[3:0] = 4'hF;
    check_output("frame_row15_data", data, lit);
    idle(1);
    check_output("frame_scan_start", 180'(colShift), 180'd1);

    // Asynchronous reset on sweep cycle 9
    idle(8);
    check_output("scan_cycle9", 180'(colShift), 180'd1);
    reset = 1'b0;
    #1;
    check_output("async_col", 180'(colShift), 180'd0);
    check_output("async_data", data, 180'd0);
    idle(2);
    reset = 1'b1;

    // Full refill plus one more row with random valid gaps
    for (int r = 0; r < NROWS + 1; r++)
      for (int k = 0; k < NPIX; k++) begin
        apply_stimulus(8'($urandom_range(0, 255)), 1'b0);
        idle($urandom_range(0, 2));
      end
    idle(30);

    $display("[TB] %0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
